pipelined_array_mult: RTL and testbench

PIPELINED_ARRAY_MULT -- requirements
Module: pipelined_array_mult

---
 rtl/pipelined_array_mult.sv | 149 ++++++++++++++
 tb/tb_pipelined_array_mult.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_array_mult.sv
// Pipelined carry-save array multiplier with valid/ready flow control and an in-flight counter.
// Define PIPELINED_ARRAY_MULT_SIGNED_EN to build in Baugh-Wooley signed support selected per operation by sgn.

module pam_row #(
    parameter int WIDTH = 8,
    parameter int ROW   = 0
) (
    input  logic [2*WIDTH-1:0] s,
    input  logic [2*WIDTH-1:0] c,
    input  logic [WIDTH-1:0]   a,
    input  logic               xb,
    input  logic               sg,
    output logic [2*WIDTH-1:0] s_o,
    output logic [2*WIDTH-1:0] c_o
);
    logic [2*WIDTH-1:0] pp;
    logic [2*WIDTH-1:0] cy;

    // Signed rows flip the MSB-column bits; the last row flips all but its MSB.
    always_comb begin
        pp = '0;
        for (int j = 0; j < WIDTH; j++)
            pp[ROW+j] = (a[j] & xb) ^ (sg && ((j == WIDTH-1) != (ROW == WIDTH-1)));
    end

    assign s_o = s ^ c ^ pp;
    assign cy  = (s & c) | (s & pp) | (c & pp);
    assign c_o = {cy[2*WIDTH-2:0], 1'b0};
endmodule

module pipelined_array_mult #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            a,
    input  logic [WIDTH-1:0]            x,
    input  logic                        sgn,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2*WIDTH-1:0]          prod,
    output logic [$clog2(STAGES+1)-1:0] inflight
);
    localparam int PW = 2*WIDTH;
    localparam int CW = $clog2(STAGES+1);

    typedef struct packed {
`ifdef PIPELINED_ARRAY_MULT_SIGNED_EN
        logic             sg;
`endif
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] x;
        logic [PW-1:0]    s;
        logic [PW-1:0]    c;
    } node_t;

    // Returns the stage index whose register sits in front of row r, or 0 if none.
    function automatic int stage_at(int r);
        for (int k = 1; k < STAGES; k++)
            if ((k*WIDTH)/STAGES == r) return k;
        return 0;
    endfunction

    node_t               head;
    node_t [WIDTH-1:0]   rout;
    logic  [STAGES:1]    vld_pipe;
    logic  [STAGES:0]    vld_next;
    logic                adv, acc, dlv;
    logic  [PW-1:0]      sum;

    assign out_valid = vld_pipe[STAGES];
    assign adv       = !(out_valid && !out_ready);
    assign in_ready  = adv;
    assign acc       = in_valid && adv;
    assign dlv       = out_valid && out_ready;
    assign vld_next  = {vld_pipe, acc};

    always_comb begin
        head   = '0;
        head.a = a;
        head.x = x;
`ifdef PIPELINED_ARRAY_MULT_SIGNED_EN
        head.sg = sgn;
        if (sgn) begin
            head.s[WIDTH] = 1'b1;
            head.s[PW-1]  = 1'b1;
        end
`endif
    end

    for (genvar r = 0; r < WIDTH; r++) begin : g_row
        node_t src;
        logic  sg_r;
        if (r == 0) begin : g_head
            assign src = head;
        end else if (stage_at(r) != 0) begin : g_reg
            node_t q;
            always_ff @(posedge clk)
                if (adv) q <= rout[r-1];
            assign src = q;
        end else begin : g_wire
            assign src = rout[r-1];
        end
`ifdef PIPELINED_ARRAY_MULT_SIGNED_EN
        assign sg_r       = src.sg;
        assign rout[r].sg = src.sg;
`else
        assign sg_r = 1'b0;
`endif
        pam_row #(.WIDTH(WIDTH), .ROW(r)) u_row (
            .s(src.s), .c(src.c), .a(src.a), .xb(src.x[0]), .sg(sg_r),
            .s_o(rout[r].s), .c_o(rout[r].c)
        );
        assign rout[r].a = src.a;
        assign rout[r].x = src.x >> 1;
    end

    // Final carry-propagate row.
    always_comb begin
        logic cy;
        cy  = 1'b0;
        sum = '0;
        for (int p = 0; p < PW; p++) begin
            sum[p] = rout[WIDTH-1].s[p] ^ rout[WIDTH-1].c[p] ^ cy;
            cy     = (rout[WIDTH-1].s[p] & rout[WIDTH-1].c[p]) |
                     (cy & (rout[WIDTH-1].s[p] ^ rout[WIDTH-1].c[p]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            prod     <= '0;
            inflight <= '0;
        end else begin
            if (adv) begin
                vld_pipe <= vld_next[STAGES-1:0];
                prod     <= sum;
            end
            if (acc && !dlv)
                inflight <= inflight + CW'(1);
            else if (dlv && !acc)
                inflight <= inflight - CW'(1);
        end
    end
endmodule

// File: tb/tb_pipelined_array_mult.sv
// Self-checking bench: directed latency/stall/reset scenarios on an 8x8 two-stage instance,
// plus a randomized scoreboard sweep across several WIDTH/STAGES builds.

module tb_pipelined_array_mult;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  x = '0;
    logic        sgn = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] prod;
    logic [1:0]  inflight;

    int errors = 0;
    int checks = 0;
    logic sw_rst = 1'b1;
    logic sweep_go = 1'b0;
    int done_cnt = 0;

    localparam int NCFG  = 12;
    localparam int N_OPS = 834;

    always #5 clk = ~clk;

    pipelined_array_mult #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .x(x), .sgn(sgn), .out_valid(out_valid), .out_ready(out_ready),
        .prod(prod), .inflight(inflight)
    );

    // Reference product: plain integer arithmetic on the operand values.
    function automatic logic [63:0] ref_mul(int w, logic s, logic [31:0] av, logic [31:0] xv);
        longint va, vx;
        logic [63:0] p;
        va = longint'(av);
        vx = longint'(xv);
`ifdef PIPELINED_ARRAY_MULT_SIGNED_EN
        if (s) begin
            if (av[w-1]) va = va - (longint'(1) << w);
            if (xv[w-1]) vx = vx - (longint'(1) << w);
        end
`endif
        p = 64'(va * vx);
        return p & ((64'd1 << (2*w)) - 64'd1);
    endfunction

    function automatic int cfg_w(int g);
        case (g / 3)
            0:       return 2;
            1:       return 5;
            2:       return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int cfg_s(int g);
        int w;
        w = cfg_w(g);
        case (g % 3)
            0:       return 1;
            1:       return w / 2;
            default: return w;
        endcase
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : g_sw
        localparam int W  = cfg_w(g);
        localparam int S  = cfg_s(g);
        localparam int CW = $clog2(S+1);
        logic           iv, ir, ov, ordy, sg;
        logic [W-1:0]   av, xv;
        logic [2*W-1:0] pr;
        logic [CW-1:0]  inf;

        pipelined_array_mult #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk(clk), .rst(sw_rst), .in_valid(iv), .in_ready(ir),
            .a(av), .x(xv), .sgn(sg), .out_valid(ov), .out_ready(ordy),
            .prod(pr), .inflight(inf)
        );

        initial begin
            logic [63:0] q[$];
            logic [63:0] ev;
            int acc_n, cyc;
            iv = 1'b0; ordy = 1'b0; av = '0; xv = '0; sg = 1'b0;
            wait (sweep_go);
            acc_n = 0;
            cyc   = 0;
            while ((acc_n < N_OPS || q.size() > 0) && cyc < 20000) begin
                @(negedge clk);
                iv   = (acc_n < N_OPS) && ($urandom_range(3) != 0);
                av   = W'($urandom);
                xv   = W'($urandom);
                sg   = 1'($urandom);
                ordy = ($urandom_range(3) != 0) || (acc_n >= N_OPS);
                #1;
                checks++;
                if (inf !== CW'(q.size())) begin
                    errors++;
                    $display("FAIL sweep_w%0d_s%0d_inflight got=%0d exp=%0d", W, S, inf, q.size());
                end
                if (ov && ordy) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL sweep_w%0d_s%0d_spurious got=%h exp=none", W, S, pr);
                    end else begin
                        ev = q.pop_front();
                        if (pr !== ev[2*W-1:0]) begin
                            errors++;
                            $display("FAIL sweep_w%0d_s%0d_prod got=%h exp=%h", W, S, pr, ev[2*W-1:0]);
                        end
                    end
                end
                if (iv && ir) begin
                    q.push_back(ref_mul(W, sg, 32'(av), 32'(xv)));
                    acc_n++;
                end
                cyc++;
            end
            checks++;
            if (cyc >= 20000) begin
                errors++;
                $display("FAIL sweep_w%0d_s%0d_budget got=%0d_ops exp=%0d_ops", W, S, acc_n, N_OPS);
            end
            iv = 1'b0;
            done_cnt++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick; tick;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (prod !== 16'h0)     begin errors++; $display("FAIL reset_prod got=%h exp=0000", prod); end
        if (inflight !== 2'd0)  begin errors++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
        rst = 1'b0;
        tick;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_unsigned_max;
        out_ready = 1'b1;
        in_valid = 1'b1; sgn = 1'b0; a = 8'hFF; x = 8'hFF;
        tick;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL umax_early got=%b exp=0", out_valid); end
        tick;
        checks += 3;
        if (out_valid !== 1'b1)  begin errors++; $display("FAIL umax_valid got=%b exp=1", out_valid); end
        if (prod !== 16'hFE01)   begin errors++; $display("FAIL umax_prod got=%h exp=fe01", prod); end
        if (inflight !== 2'd1)   begin errors++; $display("FAIL umax_inflight got=%0d exp=1", inflight); end
        tick;
        checks++;
        if (inflight !== 2'd0)   begin errors++; $display("FAIL umax_drain got=%0d exp=0", inflight); end
    endtask

    task automatic test_signed_b2b;
        logic [15:0] ev[3];
`ifdef PIPELINED_ARRAY_MULT_SIGNED_EN
        ev[0] = 16'h4000; ev[1] = 16'hFFFF; ev[2] = 16'h00FF;
`else
        ev[0] = 16'h4000; ev[1] = 16'h00FF; ev[2] = 16'h00FF;
`endif
        out_ready = 1'b1;
        in_valid = 1'b1; sgn = 1'b1; a = 8'h80; x = 8'h80;
        tick;
        sgn = 1'b1; a = 8'hFF; x = 8'h01;
        tick;
        sgn = 1'b0; a = 8'hFF; x = 8'h01;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || prod !== ev[i]) begin
                errors++;
                $display("FAIL signed_b2b_%0d got=%b/%h exp=1/%h", i, out_valid, prod, ev[i]);
            end
            tick;
            in_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] ev[16];
        logic [63:0] r;
        out_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            in_valid = (c < 16);
            if (c < 16) begin
                a = 8'($urandom); x = 8'($urandom); sgn = 1'($urandom);
                r = ref_mul(8, sgn, 32'(a), 32'(x));
                ev[c] = r[15:0];
            end
            #1;
            if (c >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || prod !== ev[c-2]) begin
                    errors++;
                    $display("FAIL b2b_prod_%0d got=%b/%h exp=1/%h", c-2, out_valid, prod, ev[c-2]);
                end
            end
            if (c >= 2 && c < 16) begin
                checks++;
                if (inflight !== 2'd2) begin errors++; $display("FAIL b2b_inflight got=%0d exp=2", inflight); end
            end
            tick;
        end
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_stall;
        logic [15:0] expq[$];
        logic [15:0] held, ev;
        logic [63:0] r;
        logic [7:0]  oa[4], ox[4];
        logic        os[4];
        int sent, got, cyc;
        for (int i = 0; i < 4; i++) begin
            oa[i] = 8'($urandom); ox[i] = 8'($urandom); os[i] = 1'($urandom);
        end
        sent = 0; got = 0; cyc = 0; held = '0;
        while (got < 4 && cyc < 40) begin
            in_valid = (sent < 4);
            if (sent < 4) begin a = oa[sent]; x = ox[sent]; sgn = os[sent]; end
            out_ready = !(cyc >= 3 && cyc < 7);
            #1;
            if (cyc == 3) begin
                checks += 2;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
                if (inflight !== 2'd2) begin errors++; $display("FAIL stall_inflight got=%0d exp=2", inflight); end
                held = prod;
            end
            if (cyc > 3 && cyc < 7) begin
                checks++;
                if (out_valid !== 1'b1 || prod !== held) begin
                    errors++;
                    $display("FAIL stall_hold got=%b/%h exp=1/%h", out_valid, prod, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL stall_spurious got=%h exp=none", prod);
                end else begin
                    ev = expq.pop_front();
                    if (prod !== ev) begin errors++; $display("FAIL stall_prod_%0d got=%h exp=%h", got, prod, ev); end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                r = ref_mul(8, sgn, 32'(a), 32'(x));
                expq.push_back(r[15:0]);
                sent++;
            end
            tick;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (got !== 4) begin errors++; $display("FAIL stall_count got=%0d exp=4", got); end
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_dup got=%b exp=0", out_valid); end
            tick;
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] r;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; a = 8'($urandom); x = 8'($urandom); sgn = 1'($urandom);
            tick;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++;
        if (inflight !== 2'd2) begin errors++; $display("FAIL rstmid_pre got=%0d exp=2", inflight); end
        rst = 1'b1;
        tick;
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0 || inflight !== 2'd0) begin
                errors++;
                $display("FAIL rstmid_flush got=%b/%0d exp=0/0", out_valid, inflight);
            end
            tick;
        end
        in_valid = 1'b1; a = 8'($urandom); x = 8'($urandom); sgn = 1'($urandom);
        r = ref_mul(8, sgn, 32'(a), 32'(x));
        tick;
        in_valid = 1'b0;
        tick;
        checks++;
        if (out_valid !== 1'b1 || prod !== r[15:0] || inflight !== 2'd1) begin
            errors++;
            $display("FAIL rstmid_next got=%b/%h/%0d exp=1/%h/1", out_valid, prod, inflight, r[15:0]);
        end
        tick;
    endtask

    task automatic test_random_sweep;
        int n;
        tick;
        sw_rst = 1'b0;
        sweep_go = 1'b1;
        n = 0;
        while (done_cnt < NCFG && n < 60000) begin
            tick;
            n++;
        end
        checks++;
        if (done_cnt != NCFG) begin
            errors++;
            $display("FAIL sweep_timeout got=%0d exp=%0d", done_cnt, NCFG);
        end
    endtask

    initial begin
        test_reset;
        test_unsigned_max;
        test_signed_b2b;
        test_back_to_back;
        test_stall;
        test_reset_mid;
        test_random_sweep;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
